text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
Character-stream writer for the 40x30 text-mode display memory; the write-side counterpart of the text renderer that reads that memory.
- Accepts ASCII bytes from the CPU/IO side over a valid/ready handshake.
- Tracks a cursor, interprets control codes, and writes character codes into display memory at address row*COLS+col.
- Clears the screen on reset and on form feed, and scrolls the screen up one row when the cursor runs past the last row.

Parameters:
COLS, 40, characters per row
ROWS, 30, rows per screen
ADDR_W, 12, display memory address width
BLANK, 8'h20, code written when clearing

Ports:
clk  input  1  clock
clr  input  1  reset, asynchronous, active-low
char_valid  input  1  char_data holds a byte to write
char_data  input  8  ASCII byte
char_ready  output  1  writer can accept a byte this cycle
mem_addr  output  ADDR_W  display memory address, shared by read and write
mem_wdata  output  8  display memory write data
mem_we  output  1  display memory write strobe
mem_re  output  1  display memory read strobe; read data is valid one cycle later
mem_rdata  input  8  display memory read data
cursor_x  output  6  cursor column, 0..COLS-1
cursor_y  output  5  cursor row, 0..ROWS-1

Behaviour:
- All outputs are registered.
- While clr=0: char_ready, mem_we, mem_re, mem_addr, mem_wdata, cursor_x and cursor_y are all 0; state is CLEAR; clear counter is 0.
- clr asserted at any time, including mid-scroll or mid-clear, aborts the operation immediately. The block restarts in CLEAR after release.
- A byte is accepted on a posedge with char_valid=1 and char_ready=1.
- char_ready=1 only in IDLE. It drops the cycle after any accept.
- Throughput is at most 1 byte per 2 cycles.

States:
- CLEAR: one write per cycle, mem_we=1, mem_wdata=BLANK, mem_addr=0..COLS*ROWS-1 (0..1199). Then cursor is set to (0,0) and the state moves to IDLE. Duration is 1200 cycles.
- IDLE: char_ready=1, mem_we=0, mem_re=0. On accept, decode char_data:
  - 0x0A LF: y+1, x unchanged, no write.
  - 0x0D CR: x=0, no write.
  - 0x08 BS: if x>0, then x-1 and write BLANK at the new position. If x=0, nothing happens; there is no reverse wrap.
  - 0x0C FF: go to CLEAR (cursor homes at the end of CLEAR).
  - Any other byte: write char_data at the current (x,y), then x+1. If x was COLS-1, then x=0 and y+1.
  - A write appears as a single mem_we pulse in the cycle following the accept edge, with the address computed from the pre-advance cursor (post-decrement for BS).
  - Next state is WAIT, or SCROLL_RD if y would become ROWS. In that case y stays ROWS-1 and x follows the rule above.
- WAIT: one cycle, char_ready=0, then IDLE.
- SCROLL_RD: mem_re=1 with mem_addr=a+COLS, for a=0..(ROWS-1)*COLS-1 (0..1159). Goes to SCROLL_WR.
- SCROLL_WR: mem_we=1, mem_addr=a, mem_wdata=mem_rdata. Then a+1, back to SCROLL_RD. After a=1159, go to SCROLL_CLR.
- SCROLL_CLR: write BLANK to 1160..1199, one per cycle, then IDLE.
- Scroll total is 2320+40 cycles. char_ready=0 throughout.
- A printable byte at (COLS-1,ROWS-1) is written to 1199 first, then the scroll runs; cursor ends at (0,29).
- Address arithmetic is ADDR_W wide: addr = y*COLS + x. With default parameters this is (y<<5)+(y<<3)+x.
- mem_we and mem_re are never both 1 in the same cycle.
- Bytes presented while char_ready=0 are held by the sender, not dropped.

Test Plan:
- Reset: release clr. Required: exactly 1200 mem_we pulses, data 0x20, addresses 0..1199 in order; then char_ready=1; cursor (0,0).
- Printable and wrap: from home send 0x41. Required: mem_we at addr 0, data 0x41; cursor (1,0). Send 40 more bytes 0x42. Required: 41st write at addr 40; cursor (1,1); char_ready low for exactly 1 cycle after each accept.
- Control codes: at cursor (5,3):
  - send 0x08. Required: write 0x20 at addr 124; cursor (4,3).
  - send 0x0D. Required: cursor (0,3); no write.
  - send 0x08. Required: no write, cursor unchanged.
  - send 0x0A. Required: cursor (0,4); no write.
- Scroll: preload row r with byte r+0x30, cursor (0,29), send 0x0A. Required:
  - reads of 40..1199;
  - addr a receives the old contents of a+40 (row 0 becomes 0x31);
  - 1160..1199 become 0x20;
  - cursor (0,29);
  - char_ready returns after 2360+ cycles.
- Wrap into scroll: cursor (39,29), send 0x5A. Required: 0x5A written at 1199, then a scroll, so 0x5A ends at 1159; cursor (0,29).
- Reset mid-scroll: assert clr 1000 cycles into a scroll. Required: all outputs 0 immediately (asynchronous). After release, a full 1200-cycle clear runs, then IDLE.

Source files
------------

// File: rtl/text_console_writer.sv
// text_console_writer
// Character-stream writer for the 40x30 text-mode display memory. Accepts
// ASCII bytes over a valid/ready handshake, tracks a cursor, interprets
// LF/CR/BS/FF, writes character codes at row*COLS+col, clears the screen
// after reset and on form feed, and scrolls up one row when the cursor
// runs past the last row. Every output is driven straight from a flop.
//
// Memory read timing: during a SCROLL_RD cycle mem_re/mem_addr are presented,
// and mem_rdata is sampled at the clock edge that ends that cycle, where it
// is registered onto mem_wdata for the following SCROLL_WR cycle.

module text_console_writer #(
  parameter int         COLS   = 40,
  parameter int         ROWS   = 30,
  parameter int         ADDR_W = 12,
  parameter logic [7:0] BLANK  = 8'h20
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [5:0]        cursor_x,
  output logic [4:0]        cursor_y
);

  localparam logic [2:0] S_CLEAR      = 3'd0;
  localparam logic [2:0] S_IDLE       = 3'd1;
  localparam logic [2:0] S_WAIT       = 3'd2;
  localparam logic [2:0] S_SCROLL_RD  = 3'd3;
  localparam logic [2:0] S_SCROLL_WR  = 3'd4;
  localparam logic [2:0] S_SCROLL_CLR = 3'd5;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] SHIFT_A = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [5:0]        X_LAST  = 6'(COLS - 1);
  localparam logic [4:0]        Y_LAST  = 5'(ROWS - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;        // clear index, or scroll source row offset a
  logic [5:0]        x_q, x_d;
  logic [4:0]        y_q, y_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              new_row;

  // Linear display address of a cursor cell.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] y, input logic [5:0] x);
    return ADDR_W'(y) * COLS_A + ADDR_W'(x);
  endfunction

  // Next-state and next-output decode; outputs are computed for the coming cycle.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    ready_d = 1'b0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    new_row = 1'b0;

    case (state_q)
      S_CLEAR, S_SCROLL_CLR: begin
        if (cnt_q == CELLS_A) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          cnt_d   = '0;
          if (state_q == S_CLEAR) begin
            x_d = '0;
            y_d = '0;
          end
        end else begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = BLANK;
          cnt_d   = cnt_q + ONE_A;
        end
      end

      S_IDLE: begin
        ready_d = 1'b1;
        if (char_valid && ready_q) begin
          ready_d = 1'b0;
          state_d = S_WAIT;
          case (char_data)
            CH_LF: new_row = 1'b1;
            CH_CR: x_d = '0;
            CH_BS: begin
              if (x_q != 6'd0) begin
                x_d     = x_q - 6'd1;
                we_d    = 1'b1;
                addr_d  = cell_addr(y_q, x_q - 6'd1);
                wdata_d = BLANK;
              end
            end
            CH_FF: begin
              state_d = S_CLEAR;
              cnt_d   = '0;
            end
            default: begin
              we_d    = 1'b1;
              addr_d  = cell_addr(y_q, x_q);
              wdata_d = char_data;
              if (x_q == X_LAST) begin
                x_d     = '0;
                new_row = 1'b1;
              end else begin
                x_d = x_q + 6'd1;
              end
            end
          endcase
          // Running off the last row keeps y on it and shifts the screen instead.
          if (new_row) begin
            if (y_q == Y_LAST) begin
              state_d = S_SCROLL_RD;
              cnt_d   = '0;
            end else begin
              y_d = y_q + 5'd1;
            end
          end
        end
      end

      S_WAIT: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end

      S_SCROLL_RD: begin
        re_d    = 1'b1;
        addr_d  = cnt_q + COLS_A;
        state_d = S_SCROLL_WR;
      end

      S_SCROLL_WR: begin
        we_d    = 1'b1;
        addr_d  = cnt_q;
        wdata_d = mem_rdata;
        cnt_d   = cnt_q + ONE_A;
        if (cnt_q == SHIFT_A - ONE_A) begin
          state_d = S_SCROLL_CLR;
        end else begin
          state_d = S_SCROLL_RD;
        end
      end

      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; clr aborts any operation immediately.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign char_ready = ready_q;
  assign mem_we     = we_q;
  assign mem_re     = re_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cursor_x   = x_q;
  assign cursor_y   = y_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Testbench for text_console_writer: directed scenarios plus a randomized
// byte stream compared against a screen/cursor model built from the
// console rules (print, wrap, LF, CR, BS, FF, scroll).

module tb_text_console_writer;

  localparam int COLS   = 40;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int CELLS  = COLS * ROWS;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              char_valid = 1'b0;
  logic [7:0]        char_data = 8'h00;
  logic              char_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata = 8'h00;
  logic [5:0]        cursor_x;
  logic [4:0]        cursor_y;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK(8'h20)) dut (
    .clk(clk), .clr(clr), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  // Display memory: writes land at the clock edge, read data is presented
  // mid-cycle so the writer samples it at the edge ending the read cycle.
  logic [7:0] mem [0:4095];
  always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;
  always @(negedge clk) if (mem_re) mem_rdata = mem[mem_addr];

  // Bus log.
  int         wr_addr [$];
  logic [7:0] wr_data [$];
  int         rd_addr [$];
  int         both_cnt = 0;
  always @(posedge clk) begin
    if (clr) begin
      if (mem_we) begin
        wr_addr.push_back(int'(mem_addr));
        wr_data.push_back(mem_wdata);
      end
      if (mem_re) rd_addr.push_back(int'(mem_addr));
      if (mem_we && mem_re) both_cnt++;
    end
  end

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    rd_addr.delete();
  endtask

  // Reference model: screen contents and cursor.
  logic [7:0] scr [0:CELLS-1];
  int mx = 0;
  int my = 0;

  function automatic void model_clear();
    for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
    mx = 0;
    my = 0;
  endfunction

  function automatic void model_newline();
    my++;
    if (my == ROWS) begin
      for (int i = 0; i < CELLS - COLS; i++) scr[i] = scr[i + COLS];
      for (int i = CELLS - COLS; i < CELLS; i++) scr[i] = 8'h20;
      my = ROWS - 1;
    end
  endfunction

  function automatic void model_put(input logic [7:0] c);
    case (c)
      8'h0A: model_newline();
      8'h0D: mx = 0;
      8'h08: if (mx > 0) begin mx--; scr[my * COLS + mx] = 8'h20; end
      8'h0C: model_clear();
      default: begin
        scr[my * COLS + mx] = c;
        mx++;
        if (mx == COLS) begin
          mx = 0;
          model_newline();
        end
      end
    endcase
  endfunction

  function automatic int screen_diffs(output int first);
    int n = 0;
    first = -1;
    for (int i = 0; i < CELLS; i++) begin
      if (mem[i] !== scr[i]) begin
        if (first < 0) first = i;
        n++;
      end
    end
    return n;
  endfunction

  task automatic wait_ready(input int budget, output int cycles);
    cycles = 0;
    while (char_ready !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Send one byte (negedge aligned). r1/r2: char_ready one and two
  // half-cycles-plus after the accept edge; lat: edges from accept to ready.
  task automatic put(input logic [7:0] c, output logic r1, output logic r2, output int lat);
    int cyc;
    wait_ready(5000, cyc);
    char_valid = 1'b1;
    char_data  = c;
    @(negedge clk);
    char_valid = 1'b0;
    r1 = char_ready;
    model_put(c);
    @(negedge clk);
    r2 = char_ready;
    wait_ready(5000, cyc);
    lat = cyc + 1;
    vectors++;
    if (char_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_timeout: char_ready=%b after byte %h, required 1", char_ready, c);
    end
  endtask

  task automatic test_reset();
    int cyc, bad;
    logic [ADDR_W+27:0] outs;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    outs = {char_ready, mem_we, mem_re, mem_addr, mem_wdata, cursor_x, cursor_y};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    clear_logs();
    clr = 1'b1;
    model_clear();
    wait_ready(1500, cyc);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] != i || wr_data[i] !== 8'h20) bad++;
    vectors++;
    if (wr_addr.size() != CELLS || bad != 0) begin
      miscompares++;
      $display("FAIL reset_clear: %0d writes (%0d wrong), required 1200 blanks in order", wr_addr.size(), bad);
    end
    vectors++;
    if (char_ready !== 1'b1 || cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_idle: ready=%b cursor=(%0d,%0d), required 1 (0,0)", char_ready, cursor_x, cursor_y);
    end
  endtask

  task automatic test_printable_wrap();
    logic r1, r2;
    int lat, bad, d, f;
    clear_logs();
    put(8'h41, r1, r2, lat);
    vectors++;
    if (wr_addr.size() != 1 || wr_addr[0] != 0 || wr_data[0] !== 8'h41) begin
      miscompares++;
      $display("FAIL print_first: %0d writes, addr %0d data %h, required 1 write 0/41", wr_addr.size(), wr_addr[0], wr_data[0]);
    end
    vectors++;
    if (cursor_x !== 6'd1 || cursor_y !== 5'd0 || r1 !== 1'b0 || r2 !== 1'b1) begin
      miscompares++;
      $display("FAIL print_cursor: (%0d,%0d) ready %b%b, required (1,0) 01", cursor_x, cursor_y, r1, r2);
    end
    clear_logs();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      put(8'h42, r1, r2, lat);
      if (r1 !== 1'b0 || r2 !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL ready_gap: %0d bytes without a single-cycle ready drop, required 0", bad);
    end
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++) if (wr_addr[i] != i + 1) bad++;
    vectors++;
    if (wr_addr.size() != 40 || bad != 0 || wr_addr[39] != 40) begin
      miscompares++;
      $display("FAIL wrap_addrs: %0d writes, %0d misplaced, required 40 at 1..40", wr_addr.size(), bad);
    end
    d = screen_diffs(f);
    vectors++;
    if (cursor_x !== 6'd1 || cursor_y !== 5'd1 || d != 0) begin
      miscompares++;
      $display("FAIL wrap_state: cursor (%0d,%0d) screen diffs %0d, required (1,1) 0", cursor_x, cursor_y, d);
    end
  endtask

  task automatic test_control();
    logic r1, r2;
    int lat;
    logic [7:0] codes [4];
    int ex [4], ey [4], ewa [4];
    codes = '{8'h08, 8'h0D, 8'h08, 8'h0A};
    ex    = '{4, 0, 0, 0};
    ey    = '{3, 3, 3, 4};
    ewa   = '{124, -1, -1, -1};
    put(8'h0D, r1, r2, lat);
    put(8'h0A, r1, r2, lat);
    put(8'h0A, r1, r2, lat);
    for (int i = 0; i < 5; i++) put(8'h43, r1, r2, lat);
    vectors++;
    if (cursor_x !== 6'd5 || cursor_y !== 5'd3) begin
      miscompares++;
      $display("FAIL ctrl_setup: cursor (%0d,%0d), required (5,3)", cursor_x, cursor_y);
    end
    for (int i = 0; i < 4; i++) begin
      clear_logs();
      put(codes[i], r1, r2, lat);
      vectors++;
      if (ewa[i] < 0 ? (wr_addr.size() != 0)
                     : (wr_addr.size() != 1 || wr_addr[0] != ewa[i] || wr_data[0] !== 8'h20)) begin
        miscompares++;
        $display("FAIL ctrl_write_%0d: %0d writes (first addr %0d), required addr %0d", i, wr_addr.size(), wr_addr[0], ewa[i]);
      end
      vectors++;
      if (cursor_x !== 6'(ex[i]) || cursor_y !== 5'(ey[i])) begin
        miscompares++;
        $display("FAIL ctrl_cursor_%0d: (%0d,%0d), required (%0d,%0d)", i, cursor_x, cursor_y, ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_scroll();
    logic r1, r2;
    int lat, bad;
    put(8'h0D, r1, r2, lat);
    while (my < ROWS - 1) put(8'h0A, r1, r2, lat);
    for (int a = 0; a < CELLS; a++) begin
      mem[a] = 8'(a / COLS + 8'h30);
      scr[a] = mem[a];
    end
    clear_logs();
    both_cnt = 0;
    put(8'h0A, r1, r2, lat);
    bad = 0;
    for (int i = 0; i < rd_addr.size(); i++) if (rd_addr[i] != COLS + i) bad++;
    vectors++;
    if (rd_addr.size() != CELLS - COLS || bad != 0) begin
      miscompares++;
      $display("FAIL scroll_reads: %0d reads, %0d misplaced, required 1160 at 40..1199", rd_addr.size(), bad);
    end
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++) if (wr_addr[i] != i) bad++;
    vectors++;
    if (wr_addr.size() != CELLS || bad != 0) begin
      miscompares++;
      $display("FAIL scroll_writes: %0d writes, %0d misplaced, required 1200 at 0..1199", wr_addr.size(), bad);
    end
    bad = 0;
    for (int a = 0; a < CELLS; a++)
      if (mem[a] !== (a < CELLS - COLS ? 8'(a / COLS + 8'h31) : 8'h20)) bad++;
    vectors++;
    if (bad != 0 || mem[0] !== 8'h31) begin
      miscompares++;
      $display("FAIL scroll_data: %0d wrong cells, row0=%h, required 0 and 31", bad, mem[0]);
    end
    vectors++;
    if (cursor_x !== 6'd0 || cursor_y !== 5'd29 || r1 !== 1'b0 || lat < 2360 || both_cnt != 0) begin
      miscompares++;
      $display("FAIL scroll_misc: cursor (%0d,%0d) ready after %0d overlap %0d, required (0,29) >=2360 0",
               cursor_x, cursor_y, lat, both_cnt);
    end
  endtask

  task automatic test_wrap_scroll();
    logic r1, r2;
    int lat, d, f;
    for (int i = 0; i < COLS - 1; i++) put(8'(8'h61 + i % 26), r1, r2, lat);
    vectors++;
    if (cursor_x !== 6'd39 || cursor_y !== 5'd29) begin
      miscompares++;
      $display("FAIL wrapscroll_setup: cursor (%0d,%0d), required (39,29)", cursor_x, cursor_y);
    end
    clear_logs();
    put(8'h5A, r1, r2, lat);
    vectors++;
    if (wr_addr.size() == 0 || wr_addr[0] != 1199 || wr_data[0] !== 8'h5A) begin
      miscompares++;
      $display("FAIL wrapscroll_first: first write %0d/%h, required 1199/5a", wr_addr[0], wr_data[0]);
    end
    d = screen_diffs(f);
    vectors++;
    if (mem[1159] !== 8'h5A || mem[1199] !== 8'h20 || cursor_x !== 6'd0 || cursor_y !== 5'd29 || d != 0) begin
      miscompares++;
      $display("FAIL wrapscroll_end: m1159=%h m1199=%h cursor (%0d,%0d) diffs %0d, required 5a 20 (0,29) 0",
               mem[1159], mem[1199], cursor_x, cursor_y, d);
    end
  endtask

  task automatic test_reset_mid_scroll();
    int cyc, bad;
    logic [ADDR_W+27:0] outs;
    wait_ready(5000, cyc);
    char_valid = 1'b1;
    char_data  = 8'h0A;
    @(negedge clk);
    char_valid = 1'b0;
    repeat (1000) @(negedge clk);
    #2 clr = 1'b0;
    #1 outs = {char_ready, mem_we, mem_re, mem_addr, mem_wdata, cursor_x, cursor_y};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: got %h, required 0", outs);
    end
    repeat (3) @(negedge clk);
    clear_logs();
    model_clear();
    clr = 1'b1;
    wait_ready(1500, cyc);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] != i || wr_data[i] !== 8'h20) bad++;
    vectors++;
    if (wr_addr.size() != CELLS || bad != 0 || rd_addr.size() != 0) begin
      miscompares++;
      $display("FAIL abort_clear: %0d writes (%0d wrong) %0d reads, required 1200 blanks 0 reads",
               wr_addr.size(), bad, rd_addr.size());
    end
    vectors++;
    if (char_ready !== 1'b1 || cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
      miscompares++;
      $display("FAIL abort_idle: ready=%b cursor (%0d,%0d), required 1 (0,0)", char_ready, cursor_x, cursor_y);
    end
  endtask

  task automatic test_random();
    logic r1, r2;
    int lat, d, f, r;
    logic [7:0] c;
    for (int i = 0; i < 26; i++) put(8'h0A, r1, r2, lat);
    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)       c = 8'h0A;
      else if (r < 12) c = 8'h0D;
      else if (r < 22) c = 8'h08;
      else if (r < 25) c = 8'h0C;
      else             c = 8'($urandom_range(8'h21, 8'h7E));
      put(c, r1, r2, lat);
      vectors++;
      if (cursor_x !== 6'(mx) || cursor_y !== 5'(my)) begin
        miscompares++;
        $display("FAIL rand_cursor #%0d byte %h: (%0d,%0d), required (%0d,%0d)", n, c, cursor_x, cursor_y, mx, my);
      end
      d = screen_diffs(f);
      vectors++;
      if (d != 0) begin
        miscompares++;
        $display("FAIL rand_screen #%0d byte %h: %0d cells differ, first %0d got %h required %h",
                 n, c, d, f, mem[f], scr[f]);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_printable_wrap();
    test_control();
    test_scroll();
    test_wrap_scroll();
    test_reset_mid_scroll();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
